// File: rtl/gpr_status_ctrl.sv
// Register-status table for the OoO core: tracks which GPRs await a ROB result
// and on which tag, and drives the architectural GPR write port at commit.
module gpr_status_ctrl #(
    parameter  int ROB_DEPTH = 16,
    localparam int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             disp_valid,
    input  logic [4:0]       disp_rd_addr,
    input  logic [TAG_W-1:0] disp_rob_tag,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic             rs1_busy,
    output logic [TAG_W-1:0] rs1_tag,
    output logic             rs2_busy,
    output logic [TAG_W-1:0] rs2_tag,
    input  logic             commit_valid,
    input  logic [4:0]       commit_rd_addr,
    input  logic [TAG_W-1:0] commit_rob_tag,
    input  logic [31:0]      commit_wdata,
    output logic             gpr_rd_wr,
    output logic [4:0]       gpr_rd_addr,
    output logic [31:0]      gpr_rd_wdata,
    output logic [5:0]       busy_cnt
);

    // Entry 0 is only ever reset, so x0 reads back as not busy with tag 0.
    logic [31:0]      busy;
    logic [TAG_W-1:0] tag_q [32];

    logic disp_set;
    logic commit_clr;
    logic cnt_inc;
    logic cnt_dec;

    always_comb begin
        disp_set   = disp_valid && (disp_rd_addr != 5'd0);
        commit_clr = commit_valid && (commit_rd_addr != 5'd0) &&
                     busy[commit_rd_addr] && (tag_q[commit_rd_addr] == commit_rob_tag);
        cnt_inc    = disp_set && !busy[disp_rd_addr];
        // A clear overridden by a same-register dispatch leaves that reg busy.
        cnt_dec    = commit_clr && !(disp_set && (disp_rd_addr == commit_rd_addr));
    end

    always_comb begin
        rs1_busy     = busy[rs1_addr];
        rs1_tag      = tag_q[rs1_addr];
        rs2_busy     = busy[rs2_addr];
        rs2_tag      = tag_q[rs2_addr];
        gpr_rd_wr    = commit_valid && (commit_rd_addr != 5'd0);
        gpr_rd_addr  = commit_rd_addr;
        gpr_rd_wdata = commit_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                tag_q[i] <= '0;
            end
        end else if (flush) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (commit_clr) begin
                busy[commit_rd_addr] <= 1'b0;
            end
            if (disp_set) begin
                busy[disp_rd_addr]  <= 1'b1;
                tag_q[disp_rd_addr] <= disp_rob_tag;
            end
            busy_cnt <= busy_cnt + 6'(cnt_inc) - 6'(cnt_dec);
        end
    end

    cnt_matches_busy: assert property (@(posedge clk) disable iff (rst)
        int'(busy_cnt) == $countones(busy));

endmodule

// File: tb/tb_gpr_status_ctrl.sv
// Self-checking bench for gpr_status_ctrl: directed vector table, hand-written
// corner sequences, then random traffic against an array-based reference model.
module tb_gpr_status_ctrl;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             disp_valid;
    logic [4:0]       disp_rd_addr;
    logic [TAG_W-1:0] disp_rob_tag;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic             rs1_busy;
    logic [TAG_W-1:0] rs1_tag;
    logic             rs2_busy;
    logic [TAG_W-1:0] rs2_tag;
    logic             commit_valid;
    logic [4:0]       commit_rd_addr;
    logic [TAG_W-1:0] commit_rob_tag;
    logic [31:0]      commit_wdata;
    logic             gpr_rd_wr;
    logic [4:0]       gpr_rd_addr;
    logic [31:0]      gpr_rd_wdata;
    logic [5:0]       busy_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpr_status_ctrl #(.ROB_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_rd_addr(disp_rd_addr), .disp_rob_tag(disp_rob_tag),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag),
        .commit_valid(commit_valid), .commit_rd_addr(commit_rd_addr),
        .commit_rob_tag(commit_rob_tag), .commit_wdata(commit_wdata),
        .gpr_rd_wr(gpr_rd_wr), .gpr_rd_addr(gpr_rd_addr), .gpr_rd_wdata(gpr_rd_wdata),
        .busy_cnt(busy_cnt)
    );

    // Reference model: one busy flag and tag per architectural register.
    bit   mbusy [32];
    logic [TAG_W-1:0] mtag [32];

    function automatic int mcount();
        int n = 0;
        for (int i = 1; i < 32; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mbusy[i] = 1'b0;
            mtag[i]  = '0;
        end
    endtask

    task automatic model_edge();
        if (flush) begin
            for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
        end else begin
            if (commit_valid && commit_rd_addr != 0 && mbusy[commit_rd_addr] &&
                mtag[commit_rd_addr] == commit_rob_tag)
                mbusy[commit_rd_addr] = 1'b0;
            if (disp_valid && disp_rd_addr != 0) begin
                mbusy[disp_rd_addr] = 1'b1;
                mtag[disp_rd_addr]  = disp_rob_tag;
            end
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit fl, input bit dv, input int drd, input int dtag,
                          input bit cv, input int crd, input int ctag, input logic [31:0] cd,
                          input int r1, input int r2);
        flush          = fl;
        disp_valid     = dv;
        disp_rd_addr   = 5'(drd);
        disp_rob_tag   = TAG_W'(dtag);
        commit_valid   = cv;
        commit_rd_addr = 5'(crd);
        commit_rob_tag = TAG_W'(ctag);
        commit_wdata   = cd;
        rs1_addr       = 5'(r1);
        rs2_addr       = 5'(r2);
    endtask

    task automatic edge_update();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    // Pre-edge checks of lookups and GPR port against the model, then count after the edge.
    task automatic model_cycle();
        #2;
        chk("rs1_busy", rs1_busy, mbusy[rs1_addr]);
        if (mbusy[rs1_addr] || rs1_addr == 0) chk("rs1_tag", rs1_tag, mtag[rs1_addr]);
        chk("rs2_busy", rs2_busy, mbusy[rs2_addr]);
        if (mbusy[rs2_addr] || rs2_addr == 0) chk("rs2_tag", rs2_tag, mtag[rs2_addr]);
        chk("gpr_rd_wr", gpr_rd_wr, commit_valid && commit_rd_addr != 0);
        if (commit_valid && commit_rd_addr != 0) begin
            chk("gpr_rd_addr", gpr_rd_addr, commit_rd_addr);
            chk("gpr_rd_wdata", gpr_rd_wdata, commit_wdata);
        end
        edge_update();
        chk("busy_cnt", busy_cnt, mcount());
        @(negedge clk);
    endtask

    typedef struct {
        bit fl; bit dv; int drd; int dtag;
        bit cv; int crd; int ctag; logic [31:0] cd;
        int r1; int r2;
        bit e1b; int e1t; bit e2b; int e2t;
        bit ewr; int ecnt;
    } vec_t;

    function automatic vec_t mk(bit fl, bit dv, int drd, int dtag, bit cv, int crd, int ctag,
                                logic [31:0] cd, int r1, int r2, bit e1b, int e1t,
                                bit e2b, int e2t, bit ewr, int ecnt);
        vec_t v;
        v.fl = fl; v.dv = dv; v.drd = drd; v.dtag = dtag;
        v.cv = cv; v.crd = crd; v.ctag = ctag; v.cd = cd;
        v.r1 = r1; v.r2 = r2;
        v.e1b = e1b; v.e1t = e1t; v.e2b = e2b; v.e2t = e2t;
        v.ewr = ewr; v.ecnt = ecnt;
        return v;
    endfunction

    vec_t tbl [13];

    initial begin
        // lookup expectations are pre-edge; ecnt is after the edge
        tbl[0]  = mk(0,0,0,0, 0,0,0,32'h0,        5,0, 0,0,0,0, 0,0);
        tbl[1]  = mk(0,1,5,3, 0,0,0,32'h0,        5,0, 0,0,0,0, 0,1);
        tbl[2]  = mk(0,0,0,0, 1,5,3,32'hDEADBEEF, 5,0, 1,3,0,0, 1,0);
        tbl[3]  = mk(0,1,7,1, 0,0,0,32'h0,        5,0, 0,0,0,0, 0,1);
        tbl[4]  = mk(0,1,7,4, 0,0,0,32'h0,        7,0, 1,1,0,0, 0,1);
        tbl[5]  = mk(0,0,0,0, 1,7,1,32'h11,       7,0, 1,4,0,0, 1,1);
        tbl[6]  = mk(0,0,0,0, 1,7,4,32'h22,       7,0, 1,4,0,0, 1,0);
        tbl[7]  = mk(0,1,9,2, 0,0,0,32'h0,        7,0, 0,0,0,0, 0,1);
        tbl[8]  = mk(0,1,9,6, 1,9,2,32'h33,       9,0, 1,2,0,0, 1,1);
        tbl[9]  = mk(0,1,0,5, 1,0,0,32'h44,       9,0, 1,6,0,0, 0,1);
        tbl[10] = mk(0,0,0,0, 1,9,6,32'h55,       0,9, 0,0,1,6, 1,0);
        tbl[11] = mk(1,1,12,1,0,0,0,32'h0,       12,0, 0,0,0,0, 0,0);
        tbl[12] = mk(0,0,0,0, 0,0,0,32'h0,       12,0, 0,0,0,0, 0,0);

        rst = 1'b1;
        set_in(0,0,0,0, 0,0,0,32'h0, 5,0);
        model_clear();
        #1;
        chk("reset_busy_cnt", busy_cnt, 0);
        chk("reset_rs1_busy", rs1_busy, 0);
        chk("reset_rs2_busy", rs2_busy, 0);
        chk("reset_gpr_rd_wr", gpr_rd_wr, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            set_in(tbl[i].fl, tbl[i].dv, tbl[i].drd, tbl[i].dtag, tbl[i].cv, tbl[i].crd,
                   tbl[i].ctag, tbl[i].cd, tbl[i].r1, tbl[i].r2);
            #2;
            chk($sformatf("vec%0d_rs1_busy", i), rs1_busy, tbl[i].e1b);
            if (tbl[i].e1b || tbl[i].r1 == 0) chk($sformatf("vec%0d_rs1_tag", i), rs1_tag, tbl[i].e1t);
            chk($sformatf("vec%0d_rs2_busy", i), rs2_busy, tbl[i].e2b);
            if (tbl[i].e2b || tbl[i].r2 == 0) chk($sformatf("vec%0d_rs2_tag", i), rs2_tag, tbl[i].e2t);
            chk($sformatf("vec%0d_gpr_rd_wr", i), gpr_rd_wr, tbl[i].ewr);
            if (tbl[i].ewr) begin
                chk($sformatf("vec%0d_gpr_rd_addr", i), gpr_rd_addr, tbl[i].crd);
                chk($sformatf("vec%0d_gpr_rd_wdata", i), gpr_rd_wdata, tbl[i].cd);
            end
            edge_update();
            chk($sformatf("vec%0d_busy_cnt", i), busy_cnt, tbl[i].ecnt);
            @(negedge clk);
        end

        // Fill x1..x31, then flush alongside a commit to x3 and a dispatch to x4.
        for (int r = 1; r < 32; r++) begin
            set_in(0,1,r,r % 16, 0,0,0,32'h0, 0,0);
            edge_update();
            @(negedge clk);
        end
        chk("full_busy_cnt", busy_cnt, 31);
        set_in(1,1,4,9, 1,3,3,32'hCAFE0003, 3,4);
        #2;
        chk("flush_rs1_busy", rs1_busy, 1);
        chk("flush_commit_wr", gpr_rd_wr, 1);
        chk("flush_commit_addr", gpr_rd_addr, 3);
        chk("flush_commit_wdata", gpr_rd_wdata, 32'hCAFE0003);
        edge_update();
        chk("flush_busy_cnt", busy_cnt, 0);
        @(negedge clk);
        set_in(0,0,0,0, 0,0,0,32'h0, 3,4);
        #2;
        chk("post_flush_rs1_busy", rs1_busy, 0);
        chk("post_flush_rs2_busy", rs2_busy, 0);
        @(negedge clk);

        // x0 dispatch and commit are inert.
        set_in(0,1,0,7, 1,0,7,32'h12345678, 0,0);
        #2;
        chk("x0_commit_wr", gpr_rd_wr, 0);
        chk("x0_rs1_busy", rs1_busy, 0);
        chk("x0_rs1_tag", rs1_tag, 0);
        edge_update();
        chk("x0_busy_cnt", busy_cnt, 0);
        @(negedge clk);
        set_in(0,0,0,0, 0,0,0,32'h0, 0,0);
        #2;
        chk("x0_after_rs1_busy", rs1_busy, 0);
        @(negedge clk);

        // Asynchronous reset between edges with four registers busy.
        for (int r = 10; r < 14; r++) begin
            set_in(0,1,r,r - 9, 0,0,0,32'h0, 0,0);
            edge_update();
            @(negedge clk);
        end
        chk("pre_rst_busy_cnt", busy_cnt, 4);
        set_in(0,0,0,0, 0,0,0,32'h0, 10,13);
        #2;
        chk("pre_rst_rs1_busy", rs1_busy, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_busy_cnt", busy_cnt, 0);
        chk("async_rst_rs1_busy", rs1_busy, 0);
        chk("async_rst_rs2_busy", rs2_busy, 0);
        #1;
        rst = 1'b0;
        model_clear();
        @(negedge clk);

        // Random traffic on a narrow register window to force collisions.
        for (int n = 0; n < 600; n++) begin
            int crd;
            int ctag;
            crd  = int'($urandom_range(0, 7));
            ctag = ($urandom_range(0, 1) == 1) ? int'(mtag[crd]) : int'($urandom_range(0, 15));
            set_in($urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                   $urandom_range(0, 1) == 1, crd, ctag, $urandom,
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            model_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
